alu_result_select: RTL

- Registered, parametrised result selector for the ALU datapath; successor to the single-bit 16-way opcode output mux.
- Selects one of NUM_SRC functional-unit results (transfer, adders, logic ops, compare, complement) by opcode, at full WIDTH, with per-source carry/overflow.
- Derives zero/negative flags, registers everything in one output stage with valid/ready handshake, and keeps a sticky overflow flag and an accepted-operation counter for the register file / status logic downstream.

---
 rtl/alu_result_select.sv | 83 ++++++++
 1 files changed

// File: rtl/alu_result_select.sv
// alu_result_select: registered opcode-indexed result selector with flags, sticky overflow and op counter
module alu_result_select #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 16,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         opcode,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [NUM_SRC-1:0]       carry_bus,
  input  logic [NUM_SRC-1:0]       ovf_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         zout,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero,
  output logic                     neg,
  output logic                     illegal,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [CNT_W-1:0]         op_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ch [2**SEL_W];
  logic cy [2**SEL_W];
  logic ov [2**SEL_W];
  logic lg [2**SEL_W];
  logic accept;
  logic [WIDTH-1:0] sel_z;
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < NUM_SRC) begin : g_src
      assign ch[k] = src_bus[k*WIDTH +: WIDTH];
      assign cy[k] = carry_bus[k];
      assign ov[k] = ovf_bus[k];
      assign lg[k] = 1'b1;
    end else begin : g_pad
      assign ch[k] = '0;
      assign cy[k] = 1'b0;
      assign ov[k] = 1'b0;
      assign lg[k] = 1'b0;
    end
  end
  assign sel_z     = ch[opcode];
  assign out_valid = state == FULL;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  always_comb begin
    state_n = accept ? FULL : out_ready ? EMPTY : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zout       <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
      neg        <= 1'b0;
      illegal    <= 1'b0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        zout    <= sel_z;
        cout    <= cy[opcode];
        ovf     <= ov[opcode];
        zero    <= sel_z == '0;
        neg     <= sel_z[WIDTH-1];
        illegal <= !lg[opcode];
      end
      sticky_ovf <= (accept && ov[opcode]) || (sticky_ovf && !clr_sticky);
      op_count   <= op_count + CNT_W'(accept);
    end
  end
endmodule
